// File: rtl/response_demux_pkg.sv
// response_demux_pkg: shared defaults and output-stage state type for the response demux
package response_demux_pkg;
  localparam int RESP_NUMBER_DEF = 8;
  localparam int RESP_WIDTH_DEF = 32;
  localparam int MAX_OUTSTANDING_DEF = 4;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: first-word-fall-through FIFO of consumer tags, extra pointer bit separates full from empty
module tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign count = wr - rd;
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
endmodule

// File: rtl/response_demux.sv
// response_demux: routes in-order responses back to the consumer whose request was issued first
module response_demux import response_demux_pkg::*; #(
  parameter int RESP_NUMBER = RESP_NUMBER_DEF,
  parameter int RESP_WIDTH = RESP_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [$clog2(RESP_NUMBER)-1:0]     issue_select,
  output logic                               issue_ready,
  input  logic                               resp_valid,
  input  logic [RESP_WIDTH-1:0]              resp_data,
  output logic                               resp_ready,
  output logic [RESP_NUMBER-1:0]             consumer_valid,
  output logic [RESP_WIDTH-1:0]              consumer_data,
  input  logic [RESP_NUMBER-1:0]             consumer_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               overflow_err
);
  localparam int SW = $clog2(RESP_NUMBER);
  state_t state;
  logic [SW-1:0] dest, tag;
  logic full, empty, accept;
  assign issue_ready = !full;
  assign resp_ready = !empty && (state == EMPTY || consumer_ready[dest]);
  assign accept = resp_valid && resp_ready;
  tag_fifo #(.WIDTH(SW), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(issue_valid),
    .pop(accept),
    .din(issue_select),
    .dout(tag),
    .full(full),
    .empty(empty),
    .count(outstanding)
  );
  // a new accept while the held response drains reloads the stage in place
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      dest <= '0;
      consumer_valid <= '0;
      consumer_data <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (issue_valid && full) overflow_err <= 1'b1;
      if (accept) begin
        state <= FULL;
        dest <= tag;
        consumer_valid <= RESP_NUMBER'(1) << tag;
        consumer_data <= resp_data;
      end else if (state == FULL && consumer_ready[dest]) begin
        state <= EMPTY;
        consumer_valid <= '0;
      end
    end
endmodule

// File: tb/tb_response_demux.sv
// tb_response_demux: directed and scoreboarded random checks of the response demux
module tb_response_demux;
  logic clk = 0, rst = 0;
  logic issue_valid = 0;
  logic [2:0] issue_select = 0;
  logic issue_ready;
  logic resp_valid = 0;
  logic [31:0] resp_data = 0;
  logic resp_ready;
  logic [7:0] consumer_valid;
  logic [31:0] consumer_data;
  logic [7:0] consumer_ready = 0;
  logic [2:0] outstanding;
  logic overflow_err;
  int checks = 0, failures = 0;
  int s1 [4] = '{0, 3, 5, 7};
  logic [34:0] tags_q[$], exp_q[$];
  int issued = 0, delivered = 0;

  always #5 clk = ~clk;

  response_demux dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_select(issue_select), .issue_ready(issue_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .consumer_valid(consumer_valid), .consumer_data(consumer_data), .consumer_ready(consumer_ready),
    .outstanding(outstanding), .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] s);
    issue_valid = 1;
    issue_select = s;
    step;
    issue_valid = 0;
  endtask

  initial begin
    #2;
    chk("rst_cv", consumer_valid, 0);
    chk("rst_cd", consumer_data, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_overflow", overflow_err, 0);
    step;
    rst = 1;
    // in-order routing to four consumers, one per cycle
    for (int i = 0; i < 4; i++) issue(3'(s1[i]));
    chk("t1_outstanding", outstanding, 4);
    chk("t1_issue_ready", issue_ready, 0);
    consumer_ready = 8'hFF;
    resp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      resp_data = 32'(s1[i] * 1000);
      #1 chk("t1_resp_ready", resp_ready, 1);
      step;
      chk("t1_cv", consumer_valid, 64'(8'h01 << s1[i]));
      chk("t1_cd", consumer_data, 64'(s1[i] * 1000));
    end
    resp_valid = 0;
    step;
    chk("t1_cv_idle", consumer_valid, 0);
    chk("t1_outstanding_end", outstanding, 0);
    // back-pressure from consumer 4 holds the stage and the next response
    issue(3'd4);
    issue(3'd2);
    consumer_ready = 8'hEF;
    resp_valid = 1;
    resp_data = 4000;
    step;
    chk("t2_cv_first", consumer_valid, 8'h10);
    resp_data = 2000;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_hold_resp_ready", resp_ready, 0);
      step;
      chk("t2_hold_cv", consumer_valid, 8'h10);
      chk("t2_hold_cd", consumer_data, 4000);
    end
    consumer_ready = 8'hFF;
    #1 chk("t2_release_resp_ready", resp_ready, 1);
    step;
    chk("t2_cv_second", consumer_valid, 8'h04);
    chk("t2_cd_second", consumer_data, 2000);
    resp_valid = 0;
    step;
    chk("t2_cv_idle", consumer_valid, 0);
    // fill, overflow, then one pop frees a slot
    for (int i = 0; i < 4; i++) issue(3'(i));
    chk("t3_outstanding_full", outstanding, 4);
    chk("t3_issue_ready", issue_ready, 0);
    chk("t3_no_overflow_yet", overflow_err, 0);
    issue(3'd5);
    chk("t3_overflow", overflow_err, 1);
    chk("t3_outstanding_kept", outstanding, 4);
    resp_valid = 1;
    resp_data = 100;
    #1 chk("t3_resp_ready", resp_ready, 1);
    step;
    chk("t3_issue_ready_back", issue_ready, 1);
    chk("t3_outstanding_3", outstanding, 3);
    chk("t3_cv0", consumer_valid, 8'h01);
    for (int i = 1; i < 4; i++) begin
      resp_data = 32'(100 + i);
      step;
      chk("t3_drain_cv", consumer_valid, 64'(8'h01 << i));
      chk("t3_drain_cd", consumer_data, 64'(100 + i));
    end
    resp_valid = 0;
    step;
    chk("t3_outstanding_end", outstanding, 0);
    chk("t3_overflow_sticky", overflow_err, 1);
    // responses with no tag are held off, including on the first issue cycle
    resp_valid = 1;
    resp_data = 55;
    #1 chk("t4_no_tag_resp_ready", resp_ready, 0);
    step;
    chk("t4_no_tag_cv", consumer_valid, 0);
    issue_valid = 1;
    issue_select = 1;
    #1 chk("t4_same_cycle_resp_ready", resp_ready, 0);
    step;
    issue_valid = 0;
    chk("t4_not_accepted_cv", consumer_valid, 0);
    #1 chk("t4_resp_ready_next", resp_ready, 1);
    step;
    chk("t4_cv", consumer_valid, 8'h02);
    chk("t4_cd", consumer_data, 55);
    resp_valid = 0;
    step;
    chk("t4_outstanding_end", outstanding, 0);
    // asynchronous reset mid-transfer
    issue(3'd6);
    issue(3'd1);
    issue(3'd2);
    issue(3'd3);
    consumer_ready = 8'hBF;
    resp_valid = 1;
    resp_data = 600;
    step;
    resp_valid = 0;
    chk("t5_cv_full", consumer_valid, 8'h40);
    chk("t5_outstanding_3", outstanding, 3);
    #1 rst = 0;
    #1;
    chk("t5_rst_cv", consumer_valid, 0);
    chk("t5_rst_outstanding", outstanding, 0);
    chk("t5_rst_cd", consumer_data, 0);
    chk("t5_rst_issue_ready", issue_ready, 1);
    chk("t5_rst_resp_ready", resp_ready, 0);
    chk("t5_rst_overflow", overflow_err, 0);
    #2 rst = 1;
    consumer_ready = 8'hFF;
    step;
    issue(3'd6);
    resp_valid = 1;
    resp_data = 6000;
    step;
    resp_valid = 0;
    chk("t5_fresh_cv", consumer_valid, 8'h40);
    chk("t5_fresh_cd", consumer_data, 6000);
    step;
    chk("t5_fresh_idle", consumer_valid, 0);
    // random in-order traffic against a scoreboard, then drain
    for (int c = 0; c < 220; c++) begin
      logic drain, hs, deliver;
      logic [2:0] idx;
      logic [34:0] dv;
      logic [63:0] e;
      drain = c >= 200;
      issue_valid = !drain && tags_q.size() < 4 && $urandom_range(1, 0) == 1;
      issue_select = 3'($urandom_range(7, 0));
      resp_valid = drain || $urandom_range(3, 0) != 0;
      resp_data = tags_q.size() != 0 ? tags_q[0][31:0] : $urandom;
      consumer_ready = drain ? 8'hFF : 8'($urandom);
      #1;
      chk("rnd_issue_ready", issue_ready, 64'(tags_q.size() < 4));
      chk("rnd_onehot", 64'($countones(consumer_valid) <= 1), 1);
      if (tags_q.size() == 0) chk("rnd_empty_resp_ready", resp_ready, 0);
      hs = resp_valid && resp_ready;
      deliver = |(consumer_valid & consumer_ready);
      idx = 0;
      for (int i = 0; i < 8; i++) if (consumer_valid[i]) idx = 3'(i);
      dv = {idx, consumer_data};
      step;
      if (deliver) begin
        e = exp_q.size() != 0 ? {29'b0, exp_q[0]} : 64'hDEAD_0000_0000_0000;
        chk("rnd_delivery", {29'b0, dv}, e);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        delivered++;
      end
      if (hs && tags_q.size() != 0) exp_q.push_back(tags_q.pop_front());
      if (issue_valid) begin
        tags_q.push_back({issue_select, 32'($urandom)});
        issued++;
      end
    end
    issue_valid = 0;
    resp_valid = 0;
    chk("rnd_delivered_all", delivered, issued);
    chk("rnd_outstanding_end", outstanding, 0);
    chk("rnd_no_overflow", overflow_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/response_demux.md
# response_demux

Return-path counterpart of `request_mux`. It records the consumer index of every request the arbiter issues into the shared resource, in issue order. When a response comes back, it routes that response to the consumer that made the request, using a valid/ready handshake per consumer. It sits between the shared resource's response port and the NCONSUMERS request/response clients, and assumes responses return strictly in issue order.

## Interface
Parameters:
- RESP_NUMBER, 8, number of consumers (≥2)
- RESP_WIDTH, 32, response payload width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  arbiter issued a request this cycle
- issue_select  in  $clog2(RESP_NUMBER)  consumer index of the issued request (same value driven on the mux select)
- issue_ready  out  1  tag FIFO can accept an issue
- resp_valid  in  1  shared resource presents a response
- resp_data  in  RESP_WIDTH  response payload
- resp_ready  out  1  response accepted when resp_valid && resp_ready
- consumer_valid  out  RESP_NUMBER  one-hot; bit i set when the response is for consumer i
- consumer_data  out  RESP_WIDTH  payload, broadcast to all consumers
- consumer_ready  in  RESP_NUMBER  per-consumer accept
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  tags held (issued, response not yet accepted)
- overflow_err  out  1  sticky; set when issue_valid is asserted while issue_ready is low

## Operation
- Tag FIFO push on issue_valid && issue_ready. Pop on resp handshake; the popped tag selects the destination consumer.
- issue_ready = !full. There is no same-cycle bypass: when the FIFO is full, issue_ready stays low even if a pop happens in the same cycle.
- An issue while issue_ready is low is dropped, and overflow_err sets. Only reset clears it.
- Output stage holds one registered response and has two states:
  - EMPTY → FULL on response accept.
  - FULL → EMPTY on consumer_ready[dest] with no new accept.
  - FULL → FULL on consumer_ready[dest] together with a new accept (reload).
- resp_ready = !tag_empty && (state==EMPTY || consumer_ready[dest]).
- A response never waits on an empty tag FIFO. It is held off: resp_ready stays low.
- consumer_ready of non-destination consumers is ignored.
- consumer_data keeps its value while FULL and not accepted. In EMPTY, consumer_data is don't-care but deterministic: it holds its last value.
- outstanding counts FIFO entries: +1 on push, −1 on pop, unchanged on both or neither.

## Timing
- Reset values (async, on rst low):
  - consumer_valid=0, consumer_data=0
  - state EMPTY, FIFO empty
  - issue_ready=1, resp_ready=0, outstanding=0, overflow_err=0
- Reset mid-operation discards all tags and any held response. No consumer sees a partial transfer.
- Latency: response accepted at edge t → consumer_valid[dest] high after edge t (one-cycle registered).
- Throughput: one response per cycle when the destination keeps consumer_ready high.
- An issue at edge t makes its tag usable from the cycle after t. A response in the same cycle as the first issue into an empty FIFO is not accepted.
- Simultaneous push and pop at depth MAX_OUTSTANDING−1 is legal, and outstanding is unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Full/empty is distinguished by an extra pointer bit.

## Structure
- Package response_demux_pkg:
  - default parameter constants
  - state enum {EMPTY, FULL}
- Sub-module `tag_fifo`: synchronous FIFO, parameters WIDTH and DEPTH. Ports push, pop, din, dout (first-word-fall-through), full, empty, count.
- The top level holds the output stage, the one-hot decode, and the error flag.

## Test plan
- Issue selects 0, 3, 5, 7; return resp_data 0, 3000, 5000, 7000; all consumer_ready=1 → consumer_valid is 8'h01, 8'h08, 8'h20, 8'h80 on consecutive cycles, each with matching data, one cycle after each accept.
- Issue select 4, hold consumer_ready[4]=0 for 5 cycles with a second response (select 2) pending → first response data 4000 stays stable on consumer 4. resp_ready stays 0 until consumer_ready[4]=1, then consumer 2 gets its data the next cycle.
- Issue 4 tags with no responses → outstanding=4, issue_ready=0. A fifth issue_valid → overflow_err=1 and outstanding stays 4. One response accepted → issue_ready=1 the next cycle.
- resp_valid=1 with no tags issued → resp_ready=0, all consumer_valid=0. Issue select 1 → response accepted the following cycle.
- Assert rst=0 while FULL with 3 outstanding → immediate consumer_valid=0 and outstanding=0. After release, a fresh issue/response to consumer 6 completes normally.
- Random in-order issue/response traffic for 200 cycles, with random consumer_ready against a scoreboard → every response reaches its issuer in order, none lost or duplicated.
